// File: rtl/pc_fetch_ctrl.sv
// Purpose: sequences PC updates and a single-outstanding IMEM fetch, with trap/redirect kill.
// Latency: returned word reaches decode in the rvalid cycle (0 cycles); PC advances on accept.
// Backpressure: i_stall parks the word in a one-entry hold buffer; no new request until it drains.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        in_rst,
  input  logic [31:0] pc,
  output logic        pc_enable,
  output logic [31:0] nxt_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        i_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] mtvec,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        kill, kill_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;

  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] seq_pc;

  assign redir     = redirect_valid | trap_valid;
  assign redir_tgt = trap_valid ? {mtvec[31:2], 2'b00} : {redirect_pc[31:2], 2'b00};
  assign seq_pc    = pc + 32'd4;

  // State, kill flag and hold buffer registers; reset clears everything immediately.
  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      state      <= BOOT;
      kill       <= 1'b0;
      hold_instr <= 32'h0;
      hold_pc    <= 32'h0;
    end else begin
      state      <= state_nxt;
      kill       <= kill_nxt;
      hold_instr <= hold_instr_nxt;
      hold_pc    <= hold_pc_nxt;
    end
  end

  // Next-state and output decode; outputs held at 0 while reset is asserted.
  always_comb begin
    state_nxt      = state;
    kill_nxt       = kill;
    hold_instr_nxt = hold_instr;
    hold_pc_nxt    = hold_pc;
    pc_enable      = 1'b0;
    nxt_pc         = 32'h0;
    imem_req       = 1'b0;
    imem_addr      = 32'h0;
    if_valid       = 1'b0;
    if_instr       = 32'h0;
    if_pc          = 32'h0;

    if (in_rst) begin
      case (state)
        BOOT: begin
          pc_enable = 1'b1;
          nxt_pc    = RESET_PC;
          state_nxt = REQ;
        end
        REQ: begin
          imem_req  = 1'b1;
          imem_addr = pc;
          if (redir) begin
            pc_enable = 1'b1;
            nxt_pc    = redir_tgt;
            // A grant in the redirect cycle fetches the stale address: kill its data.
            if (imem_gnt) begin
              state_nxt = WAIT;
              kill_nxt  = 1'b1;
            end
          end else if (imem_gnt) begin
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (redir) begin
            pc_enable = 1'b1;
            nxt_pc    = redir_tgt;
            if (imem_rvalid) begin
              kill_nxt  = 1'b0;
              state_nxt = REQ;
            end else begin
              kill_nxt  = 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill_nxt  = 1'b0;
              state_nxt = REQ;
            end else begin
              if_valid = 1'b1;
              if_instr = imem_rdata;
              if_pc    = pc;
              if (i_stall) begin
                hold_instr_nxt = imem_rdata;
                hold_pc_nxt    = pc;
                state_nxt      = HOLD;
              end else begin
                pc_enable = 1'b1;
                nxt_pc    = seq_pc;
                state_nxt = REQ;
              end
            end
          end
        end
        HOLD: begin
          if (redir) begin
            pc_enable = 1'b1;
            nxt_pc    = redir_tgt;
            state_nxt = REQ;
          end else begin
            if_valid = 1'b1;
            if_instr = hold_instr;
            if_pc    = hold_pc;
            if (!i_stall) begin
              pc_enable = 1'b1;
              nxt_pc    = seq_pc;
              state_nxt = REQ;
            end
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a simple PC register model around it.
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_pc_fetch_ctrl;

  logic        i_clk = 1'b0;
  logic        in_rst = 1'b0;
  logic [31:0] pc;
  logic        pc_enable;
  logic [31:0] nxt_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        i_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        trap_valid = 1'b0;
  logic [31:0] mtvec = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  // PC register the controller drives.
  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) pc <= 32'h0;
    else if (pc_enable) pc <= nxt_pc;
  end

  pc_fetch_ctrl #(.RESET_PC(32'h80)) dut (
    .i_clk(i_clk), .in_rst(in_rst), .pc(pc),
    .pc_enable(pc_enable), .nxt_pc(nxt_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .i_stall(i_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .mtvec(mtvec),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    step(); step(); settle();
    tests++; if ({pc_enable, imem_req, if_valid} !== 3'b000) begin fails++; $display("FAIL reset_strobes got %b want 000", {pc_enable, imem_req, if_valid}); end
    tests++; if ({nxt_pc, imem_addr, if_instr, if_pc} !== 128'h0) begin fails++; $display("FAIL reset_buses got %h want 0", {nxt_pc, imem_addr, if_instr, if_pc}); end
  endtask

  task automatic test_boot_fetch();
    step(); in_rst = 1'b1; settle();
    tests++; if ({pc_enable, nxt_pc} !== {1'b1, 32'h80}) begin fails++; $display("FAIL boot_load got %b/%h want 1/00000080", pc_enable, nxt_pc); end
    step(); imem_gnt = 1'b1; settle();
    tests++; if ({imem_req, imem_addr, pc} !== {1'b1, 32'h80, 32'h80}) begin fails++; $display("FAIL boot_req got %b/%h/%h want 1/80/80", imem_req, imem_addr, pc); end
    step(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA1A1_0001; settle();
    tests++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h80, 32'hA1A1_0001}) begin fails++; $display("FAIL boot_ifout got %b/%h/%h want 1/80/a1a10001", if_valid, if_pc, if_instr); end
    tests++; if ({pc_enable, nxt_pc, imem_req} !== {1'b1, 32'h84, 1'b0}) begin fails++; $display("FAIL boot_advance got %b/%h/%b want 1/84/0", pc_enable, nxt_pc, imem_req); end
    step(); imem_rvalid = 1'b0; settle();
    tests++; if ({if_valid, pc, imem_req, imem_addr} !== {1'b0, 32'h84, 1'b1, 32'h84}) begin fails++; $display("FAIL boot_next got %b/%h/%b/%h want 0/84/1/84", if_valid, pc, imem_req, imem_addr); end
  endtask

  task automatic test_stall_hold();
    // Steer to 0x10 while the request is waiting for a grant.
    redirect_valid = 1'b1; redirect_pc = 32'h10; settle();
    tests++; if ({pc_enable, nxt_pc, imem_req} !== {1'b1, 32'h10, 1'b1}) begin fails++; $display("FAIL req_redirect got %b/%h/%b want 1/10/1", pc_enable, nxt_pc, imem_req); end
    step(); redirect_valid = 1'b0; imem_gnt = 1'b1; settle();
    tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin fails++; $display("FAIL req_newaddr got %b/%h want 1/10", imem_req, imem_addr); end
    step(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB2B2_0002; i_stall = 1'b1; settle();
    tests++; if ({if_valid, if_instr, pc_enable} !== {1'b1, 32'hB2B2_0002, 1'b0}) begin fails++; $display("FAIL stall_first got %b/%h/%b want 1/b2b20002/0", if_valid, if_instr, pc_enable); end
    for (int i = 0; i < 2; i++) begin
      step(); imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF; settle();
      tests++; if ({if_valid, if_instr, if_pc, pc, imem_req, pc_enable} !== {1'b1, 32'hB2B2_0002, 32'h10, 32'h10, 1'b0, 1'b0}) begin fails++; $display("FAIL stall_hold%0d got %b/%h/%h/%h/%b/%b want 1/b2b20002/10/10/0/0", i, if_valid, if_instr, if_pc, pc, imem_req, pc_enable); end
    end
    step(); i_stall = 1'b0; settle();
    tests++; if ({if_valid, if_instr, pc_enable, nxt_pc} !== {1'b1, 32'hB2B2_0002, 1'b1, 32'h14}) begin fails++; $display("FAIL stall_release got %b/%h/%b/%h want 1/b2b20002/1/14", if_valid, if_instr, pc_enable, nxt_pc); end
    step(); settle();
    tests++; if ({pc, if_valid, imem_req} !== {32'h14, 1'b0, 1'b1}) begin fails++; $display("FAIL stall_after got %h/%b/%b want 14/0/1", pc, if_valid, imem_req); end
  endtask

  task automatic test_redirect_kill();
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h203; settle();
    tests++; if ({pc_enable, nxt_pc, if_valid} !== {1'b1, 32'h200, 1'b0}) begin fails++; $display("FAIL wait_redirect got %b/%h/%b want 1/200/0", pc_enable, nxt_pc, if_valid); end
    step(); redirect_valid = 1'b0; settle();
    tests++; if ({pc, imem_req} !== {32'h200, 1'b0}) begin fails++; $display("FAIL kill_wait got %h/%b want 200/0", pc, imem_req); end
    step(); imem_rvalid = 1'b1; imem_rdata = 32'hC3C3_0003; settle();
    tests++; if ({if_valid, pc_enable} !== 2'b00) begin fails++; $display("FAIL kill_drop got %b%b want 00", if_valid, pc_enable); end
    step(); imem_rvalid = 1'b0; settle();
    tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin fails++; $display("FAIL kill_refetch got %b/%h want 1/200", imem_req, imem_addr); end
  endtask

  task automatic test_trap_priority();
    trap_valid = 1'b1; redirect_valid = 1'b1; mtvec = 32'h101; redirect_pc = 32'h400; settle();
    tests++; if ({pc_enable, nxt_pc} !== {1'b1, 32'h100}) begin fails++; $display("FAIL trap_wins got %b/%h want 1/100", pc_enable, nxt_pc); end
    step(); trap_valid = 1'b0; redirect_valid = 1'b0; settle();
    tests++; if ({pc, imem_addr} !== {32'h100, 32'h100}) begin fails++; $display("FAIL trap_target got %h/%h want 100/100", pc, imem_addr); end
  endtask

  task automatic test_back_to_back();
    // Redirect and grant in the same cycle: the granted fetch must be killed.
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
    tests++; if ({pc_enable, nxt_pc} !== {1'b1, 32'hFFFF_FFFC}) begin fails++; $display("FAIL gnt_redirect got %b/%h want 1/fffffffc", pc_enable, nxt_pc); end
    step(); imem_gnt = 1'b0; redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hD4D4_0004; settle();
    tests++; if ({if_valid, pc} !== {1'b0, 32'hFFFF_FFFC}) begin fails++; $display("FAIL gnt_kill got %b/%h want 0/fffffffc", if_valid, pc); end
    step(); imem_rvalid = 1'b0; settle();
    tests++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin fails++; $display("FAIL gnt_refetch got %b/%h want 1/fffffffc", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hE5E5_0005; settle();
    tests++; if ({if_valid, if_pc, nxt_pc, pc_enable} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1}) begin fails++; $display("FAIL wrap_seq got %b/%h/%h/%b want 1/fffffffc/0/1", if_valid, if_pc, nxt_pc, pc_enable); end
    step(); imem_rvalid = 1'b0; settle();
    tests++; if ({pc, imem_addr} !== {32'h0, 32'h0}) begin fails++; $display("FAIL wrap_pc got %h/%h want 0/0", pc, imem_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0; in_rst = 1'b0; settle();
    tests++; if ({pc_enable, imem_req, if_valid, nxt_pc} !== 35'h0) begin fails++; $display("FAIL rst_wait got %b%b%b/%h want 000/0", pc_enable, imem_req, if_valid, nxt_pc); end
    step(); imem_rvalid = 1'b1; imem_rdata = 32'hF6F6_0006; settle();
    tests++; if ({if_valid, if_instr, pc_enable, pc} !== 66'h0) begin fails++; $display("FAIL rst_rvalid got %b/%h/%b/%h want 0/0/0/0", if_valid, if_instr, pc_enable, pc); end
    step(); imem_rvalid = 1'b0; in_rst = 1'b1; settle();
    tests++; if ({pc_enable, nxt_pc, if_valid} !== {1'b1, 32'h80, 1'b0}) begin fails++; $display("FAIL rst_boot got %b/%h/%b want 1/80/0", pc_enable, nxt_pc, if_valid); end
    step(); imem_rvalid = 1'b1; settle();
    tests++; if ({pc, imem_req, imem_addr, if_valid} !== {32'h80, 1'b1, 32'h80, 1'b0}) begin fails++; $display("FAIL rst_stale got %h/%b/%h/%b want 80/1/80/0", pc, imem_req, imem_addr, if_valid); end
    step(); imem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_stall_hold();
    test_redirect_kill();
    step();
    test_trap_priority();
    step();
    test_back_to_back();
    step();
    test_wrap();
    step();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
